reservation_station: RTL
========================

Name: reservation_station

Overview:
- Receiving end of the decoder's RS dispatch interface.
- Buffers dispatched ALU and branch ops and snoops two result broadcast buses (ALU and LSB) to resolve operand dependencies.
- Issues at most one ready op per cycle to the ALU.
- Sits between the decoder, ALU, load-store buffer and reorder buffer; the reorder buffer flushes it on misprediction.

Parameters:
- RS_SIZE, 8: number of entries (power of 2, ≥2).
- ROB_WIDTH_BIT, 3: ROB index width, equal to the global `ROB_WIDTH_BIT`.
- RS_TYPE_BIT, 6: op type width, {mul, branch, sub/sra, func3}.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  ready; when low, all state holds.
- clear_in  in  1  flush from ROB.
- rs_valid  in  1  dispatch strobe, one cycle per op.
- rs_type  in  RS_TYPE_BIT  op type.
- rs_r1  in  32  operand 1 value, meaningful when no dependency.
- rs_r2  in  32  operand 2 value or immediate.
- rs_has_dep1  in  1  operand 1 waits on a ROB entry.
- rs_has_dep2  in  1  operand 2 waits on a ROB entry.
- rs_dep1  in  ROB_WIDTH_BIT  producer ROB id for operand 1.
- rs_dep2  in  ROB_WIDTH_BIT  producer ROB id for operand 2.
- rs_rob_id  in  ROB_WIDTH_BIT  destination ROB id.
- rs_full  out  1  back-pressure to decoder.
- alu_cdb_valid  in  1  ALU result broadcast.
- alu_cdb_rob_id  in  ROB_WIDTH_BIT  ROB id of ALU result.
- alu_cdb_value  in  32  ALU result value.
- lsb_cdb_valid  in  1  load result broadcast.
- lsb_cdb_rob_id  in  ROB_WIDTH_BIT  ROB id of load result.
- lsb_cdb_value  in  32  load result value.
- alu_valid  out  1  issue strobe.
- alu_type  out  RS_TYPE_BIT  issued op type.
- alu_r1  out  32  issued operand 1.
- alu_r2  out  32  issued operand 2.
- alu_rob_id  out  ROB_WIDTH_BIT  issued destination ROB id.

Behaviour:
- Reset (rst_in low, asynchronous): all entries invalid; alu_valid=0, alu_type=0, alu_r1=0, alu_r2=0, alu_rob_id=0. rs_full reflects the empty state, i.e. 0 unless rs_valid is asserted with RS_SIZE=1 (not a legal configuration).
- Entry contents: busy, type, v1, v2, has1, has2, q1, q2, rob_id.
- Dispatch:
  - When rs_valid=1 and clear_in=0, write the lowest-index free entry at the clock edge.
  - If alu_cdb or lsb_cdb broadcasts an id equal to rs_dep1 or rs_dep2 in the same cycle, the entry captures the value and clears the matching has bit (same-cycle bypass). Otherwise it stores the fields as given.
- Snoop: every cycle, each busy entry with has1 set and q1 equal to a valid CDB id takes that value and clears has1; has2/q2 likewise. If both buses match the same id, the ALU bus wins; this case is illegal but the result must be deterministic.
- Readiness: an entry is ready when busy && !has1 && !has2, evaluated on registered state. A dispatched or just-woken entry issues no earlier than the next cycle.
- Issue:
  - Each cycle, select one ready entry, lowest index by default.
  - On the next edge: alu_valid=1, alu_* load the entry fields, and the entry is freed.
  - With no ready entry, alu_valid=0 on the next edge.
  - alu_valid is a one-cycle pulse per op; the ALU never back-pressures.
  - Issue-to-ALU latency from last operand wakeup: 1 cycle after the entry's registered state becomes ready.
- rs_full (combinational): 1 when free==0, or when free==1 and rs_valid=1.
  - This covers the decoder's registered one-cycle dispatch lag.
  - Frees from same-cycle issue are not counted (conservative).
- Dispatch while full is a protocol violation. The write is dropped and simulation prints an error under `ifndef SYNTHESIS`.
- clear_in (synchronous):
  - On the next edge, all entries become invalid and alu_valid=0.
  - It has priority over same-cycle dispatch and issue; the dispatched op is discarded.
- rdy_in=0: no register changes, including alu_valid, CDB captures and dispatch. Upstream guarantees no strobes are lost.
- Simultaneous dispatch, snoop, issue and free in one cycle are all legal. A freed entry is reusable from the following cycle only.

Optional Feature:
- Macro RS_ISSUE_OLDEST_EN.
- When defined:
  - Each entry holds a ceil(log2(RS_SIZE))+1-bit age counter, set to 0 on dispatch and incremented for all other busy entries on each dispatch (saturating).
  - Issue selects the ready entry with the largest age; ties go to the lowest index.
- When undefined: lowest-index ready selection, with no age state.

Test Plan:
- Reset mid-operation: after 3 dispatches, pulse rst_in low for 1 cycle → all entries free, alu_valid=0, rs_full=0 immediately (asynchronous).
- Dispatch with no dependencies (add, r1=5, r2=7, rob_id=2) → cycle+1 alu_valid=1, alu_r1=5, alu_r2=7, alu_rob_id=2; following cycle alu_valid=0.
- Dispatch with has_dep1=1, dep1=4; 3 cycles later alu_cdb (id 4, value 0x10) → issue 1 cycle after capture with alu_r1=0x10. Repeat with the lsb_cdb broadcast in the dispatch cycle → captured, issue next cycle.
- Fill RS_SIZE=8 with blocked ops → rs_full=1 when 7 are held and rs_valid=1. Broadcast the shared dep → ops issue in index order, one per cycle, alu_valid high for 8 consecutive cycles.
- clear_in asserted with 4 entries busy and a same-cycle dispatch → no alu_valid afterwards; rs_full=0; a new op dispatched 1 cycle later issues normally.
- RS_ISSUE_OLDEST_EN: entry 3 (older) and entry 0 (newer) become ready in the same cycle → entry 3 issues first. Without the macro → entry 0 issues first.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ALU/branch ops, snoops the ALU and LSB result
// buses and issues one ready op per cycle. Define RS_ISSUE_OLDEST_EN for oldest-first issue.
module reservation_station #(
  parameter int RS_SIZE       = 8,
  parameter int ROB_WIDTH_BIT = 3,
  parameter int RS_TYPE_BIT   = 6
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic                     rs_valid,
  input  logic [RS_TYPE_BIT-1:0]   rs_type,
  input  logic [31:0]              rs_r1,
  input  logic [31:0]              rs_r2,
  input  logic                     rs_has_dep1,
  input  logic                     rs_has_dep2,
  input  logic [ROB_WIDTH_BIT-1:0] rs_dep1,
  input  logic [ROB_WIDTH_BIT-1:0] rs_dep2,
  input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
  output logic                     rs_full,
  input  logic                     alu_cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] alu_cdb_rob_id,
  input  logic [31:0]              alu_cdb_value,
  input  logic                     lsb_cdb_valid,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_cdb_rob_id,
  input  logic [31:0]              lsb_cdb_value,
  output logic                     alu_valid,
  output logic [RS_TYPE_BIT-1:0]   alu_type,
  output logic [31:0]              alu_r1,
  output logic [31:0]              alu_r2,
  output logic [ROB_WIDTH_BIT-1:0] alu_rob_id
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]       busy_q, busy_d, has1_q, has1_d, has2_q, has2_d, ready;
  logic [RS_TYPE_BIT-1:0]   type_q [RS_SIZE];
  logic [RS_TYPE_BIT-1:0]   type_d [RS_SIZE];
  logic [31:0]              v1_q   [RS_SIZE];
  logic [31:0]              v1_d   [RS_SIZE];
  logic [31:0]              v2_q   [RS_SIZE];
  logic [31:0]              v2_d   [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] q1_q   [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] q1_d   [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] q2_q   [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] q2_d   [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] rob_q  [RS_SIZE];
  logic [ROB_WIDTH_BIT-1:0] rob_d  [RS_SIZE];

  logic                     aluValid_q, aluValid_d;
  logic [RS_TYPE_BIT-1:0]   aluType_q, aluType_d;
  logic [31:0]              aluR1_q, aluR1_d, aluR2_q, aluR2_d;
  logic [ROB_WIDTH_BIT-1:0] aluRob_q, aluRob_d;

  logic [IDX_W:0]   freeCnt;
  logic [IDX_W-1:0] dispSlot, issSlot;
  logic             dispFound, issFound, dispAccept;
  logic             d1Alu, d1Lsb, d2Alu, d2Lsb;

  assign ready      = busy_q & ~has1_q & ~has2_q;
  assign dispAccept = rs_valid && dispFound;
  assign d1Alu      = alu_cdb_valid && (alu_cdb_rob_id == rs_dep1);
  assign d1Lsb      = lsb_cdb_valid && (lsb_cdb_rob_id == rs_dep1);
  assign d2Alu      = alu_cdb_valid && (alu_cdb_rob_id == rs_dep2);
  assign d2Lsb      = lsb_cdb_valid && (lsb_cdb_rob_id == rs_dep2);

  // Free count and lowest free slot come from registered state only, so a slot
  // freed by this cycle's issue is not reused until the next cycle.
  always_comb begin
    freeCnt   = '0;
    dispFound = 1'b0;
    dispSlot  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        freeCnt   = freeCnt + (IDX_W + 1)'(1);
        dispFound = 1'b1;
        dispSlot  = IDX_W'(i);
      end
    end
  end

  assign rs_full = (freeCnt == '0) || ((freeCnt == (IDX_W + 1)'(1)) && rs_valid);

`ifdef RS_ISSUE_OLDEST_EN
  localparam int AGE_W = IDX_W + 1;
  logic [AGE_W-1:0] age_q [RS_SIZE];
  logic [AGE_W-1:0] age_d [RS_SIZE];
  logic [AGE_W-1:0] bestAge;

  // Strict greater-than keeps ties on the lowest index.
  always_comb begin
    issFound = 1'b0;
    issSlot  = '0;
    bestAge  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!issFound || (age_q[i] > bestAge))) begin
        issFound = 1'b1;
        issSlot  = IDX_W'(i);
        bestAge  = age_q[i];
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (dispAccept) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && (age_q[i] != '1)) age_d[i] = age_q[i] + AGE_W'(1);
      end
      age_d[dispSlot] = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
    end else if (rdy_in) begin
      age_q <= age_d;
    end
  end
`else
  always_comb begin
    issFound = 1'b0;
    issSlot  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issFound = 1'b1;
        issSlot  = IDX_W'(i);
      end
    end
  end
`endif

  // Snoop, issue, dispatch, then flush last so it overrides everything else.
  always_comb begin
    busy_d = busy_q;
    has1_d = has1_q;
    has2_d = has2_q;
    type_d = type_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    q1_d   = q1_q;
    q2_d   = q2_q;
    rob_d  = rob_q;
    aluValid_d = 1'b0;
    aluType_d  = aluType_q;
    aluR1_d    = aluR1_q;
    aluR2_d    = aluR2_q;
    aluRob_d   = aluRob_q;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && has1_q[i]) begin
        if (alu_cdb_valid && (alu_cdb_rob_id == q1_q[i])) begin
          v1_d[i] = alu_cdb_value;  has1_d[i] = 1'b0;
        end else if (lsb_cdb_valid && (lsb_cdb_rob_id == q1_q[i])) begin
          v1_d[i] = lsb_cdb_value;  has1_d[i] = 1'b0;
        end
      end
      if (busy_q[i] && has2_q[i]) begin
        if (alu_cdb_valid && (alu_cdb_rob_id == q2_q[i])) begin
          v2_d[i] = alu_cdb_value;  has2_d[i] = 1'b0;
        end else if (lsb_cdb_valid && (lsb_cdb_rob_id == q2_q[i])) begin
          v2_d[i] = lsb_cdb_value;  has2_d[i] = 1'b0;
        end
      end
    end

    if (issFound) begin
      aluValid_d      = 1'b1;
      aluType_d       = type_q[issSlot];
      aluR1_d         = v1_q[issSlot];
      aluR2_d         = v2_q[issSlot];
      aluRob_d        = rob_q[issSlot];
      busy_d[issSlot] = 1'b0;
    end

    if (dispAccept) begin
      busy_d[dispSlot] = 1'b1;
      type_d[dispSlot] = rs_type;
      q1_d[dispSlot]   = rs_dep1;
      q2_d[dispSlot]   = rs_dep2;
      rob_d[dispSlot]  = rs_rob_id;
      if (rs_has_dep1 && d1Alu) begin
        v1_d[dispSlot] = alu_cdb_value;  has1_d[dispSlot] = 1'b0;
      end else if (rs_has_dep1 && d1Lsb) begin
        v1_d[dispSlot] = lsb_cdb_value;  has1_d[dispSlot] = 1'b0;
      end else begin
        v1_d[dispSlot] = rs_r1;          has1_d[dispSlot] = rs_has_dep1;
      end
      if (rs_has_dep2 && d2Alu) begin
        v2_d[dispSlot] = alu_cdb_value;  has2_d[dispSlot] = 1'b0;
      end else if (rs_has_dep2 && d2Lsb) begin
        v2_d[dispSlot] = lsb_cdb_value;  has2_d[dispSlot] = 1'b0;
      end else begin
        v2_d[dispSlot] = rs_r2;          has2_d[dispSlot] = rs_has_dep2;
      end
    end

    if (clear_in) begin
      busy_d     = '0;
      aluValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      has1_q <= '0;
      has2_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        type_q[i] <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        rob_q[i]  <= '0;
      end
      aluValid_q <= 1'b0;
      aluType_q  <= '0;
      aluR1_q    <= '0;
      aluR2_q    <= '0;
      aluRob_q   <= '0;
    end else if (rdy_in) begin
      busy_q <= busy_d;
      has1_q <= has1_d;
      has2_q <= has2_d;
      type_q <= type_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      q1_q   <= q1_d;
      q2_q   <= q2_d;
      rob_q  <= rob_d;
      aluValid_q <= aluValid_d;
      aluType_q  <= aluType_d;
      aluR1_q    <= aluR1_d;
      aluR2_q    <= aluR2_d;
      aluRob_q   <= aluRob_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !clear_in && rs_valid && !dispFound)
      $error("reservation_station: dispatch while full, op dropped");
  end
`endif

  assign alu_valid  = aluValid_q;
  assign alu_type   = aluType_q;
  assign alu_r1     = aluR1_q;
  assign alu_r2     = aluR2_q;
  assign alu_rob_id = aluRob_q;

endmodule
